// File: rtl/ctl_seq.sv
// ctl_seq: instruction sequencer for the accumulator core.
// Walks fetch -> decode -> optional execute, driving the address unit
// (marmux / MAR / PC), the IR load, the accumulator/ALU and the memory
// strobe/write handshake. State is Moore; enables are qualified by ack_i.

`ifndef CTR_MARMUX_WIDTH
`define CTR_MARMUX_WIDTH 1
`endif
`ifndef MAR_OP_PC
`define MAR_OP_PC 0
`endif
`ifndef MAR_OP_ARG
`define MAR_OP_ARG 1
`endif

module ctl_seq #(
  parameter int OPC_WIDTH        = 4,
  parameter int CTR_MARMUX_WIDTH = `CTR_MARMUX_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [OPC_WIDTH-1:0]        opc_i,
  input  logic                        ack_i,
  input  logic                        acc_zero_i,
  output logic                        stb_o,
  output logic                        we_o,
  output logic [CTR_MARMUX_WIDTH-1:0] ctr_marmux_o,
  output logic                        ctr_mar_reg_en_o,
  output logic                        ctr_pc_reg_en_o,
  output logic                        ir_en_o,
  output logic                        acc_en_o,
  output logic [1:0]                  alu_op_o,
  output logic                        halt_o
);

  localparam logic [CTR_MARMUX_WIDTH-1:0] MUX_PC  = CTR_MARMUX_WIDTH'(`MAR_OP_PC);
  localparam logic [CTR_MARMUX_WIDTH-1:0] MUX_ARG = CTR_MARMUX_WIDTH'(`MAR_OP_ARG);

  localparam logic [OPC_WIDTH-1:0] OP_LDA = OPC_WIDTH'(4'h1);
  localparam logic [OPC_WIDTH-1:0] OP_STA = OPC_WIDTH'(4'h2);
  localparam logic [OPC_WIDTH-1:0] OP_ADD = OPC_WIDTH'(4'h3);
  localparam logic [OPC_WIDTH-1:0] OP_SUB = OPC_WIDTH'(4'h4);
  localparam logic [OPC_WIDTH-1:0] OP_AND = OPC_WIDTH'(4'h5);
  localparam logic [OPC_WIDTH-1:0] OP_JMP = OPC_WIDTH'(4'h6);
  localparam logic [OPC_WIDTH-1:0] OP_JZ  = OPC_WIDTH'(4'h7);
  localparam logic [OPC_WIDTH-1:0] OP_HLT = OPC_WIDTH'(4'hF);

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_AND  = 2'd3;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [OPC_WIDTH-1:0]   opc_q;

  // Opcode classes taken from the latched instruction.
  logic is_mem_op, take_branch;
  assign is_mem_op   = (opc_q == OP_LDA) || (opc_q == OP_STA) || (opc_q == OP_ADD) ||
                       (opc_q == OP_SUB) || (opc_q == OP_AND);
  assign take_branch = (opc_q == OP_JMP) || ((opc_q == OP_JZ) && acc_zero_i);

  // Next state and ack-qualified outputs; reset overrides everything to idle.
  always_comb begin
    state_d          = state_q;
    stb_o            = 1'b0;
    we_o             = 1'b0;
    ctr_marmux_o     = MUX_PC;
    ctr_mar_reg_en_o = 1'b0;
    ctr_pc_reg_en_o  = 1'b0;
    ir_en_o          = 1'b0;
    acc_en_o         = 1'b0;
    alu_op_o         = ALU_PASS;
    halt_o           = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        stb_o = 1'b1;
        if (ack_i) begin
          ir_en_o         = 1'b1;
          ctr_pc_reg_en_o = 1'b1;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opc_q == OP_HLT) begin
          state_d = S_HALT;
        end else if (is_mem_op) begin
          ctr_marmux_o     = MUX_ARG;
          ctr_mar_reg_en_o = 1'b1;
          state_d          = S_EXEC;
        end else if (take_branch) begin
          // PC picks up target+1 on the following fetch ack.
          ctr_marmux_o     = MUX_ARG;
          ctr_mar_reg_en_o = 1'b1;
          state_d          = S_FETCH;
        end else begin
          // NOP, untaken JZ and unassigned codes: MAR re-points at PC.
          ctr_marmux_o     = MUX_PC;
          ctr_mar_reg_en_o = 1'b1;
          state_d          = S_FETCH;
        end
      end
      S_EXEC: begin
        stb_o = 1'b1;
        we_o  = (opc_q == OP_STA);
        case (opc_q)
          OP_ADD:  alu_op_o = ALU_ADD;
          OP_SUB:  alu_op_o = ALU_SUB;
          OP_AND:  alu_op_o = ALU_AND;
          default: alu_op_o = ALU_PASS;
        endcase
        if (ack_i) begin
          acc_en_o         = (opc_q != OP_STA);
          ctr_marmux_o     = MUX_PC;
          ctr_mar_reg_en_o = 1'b1;
          state_d          = S_FETCH;
        end
      end
      S_HALT: begin
        halt_o = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst_i) begin
      state_d          = S_FETCH;
      stb_o            = 1'b0;
      we_o             = 1'b0;
      ctr_marmux_o     = MUX_PC;
      ctr_mar_reg_en_o = 1'b0;
      ctr_pc_reg_en_o  = 1'b0;
      ir_en_o          = 1'b0;
      acc_en_o         = 1'b0;
      alu_op_o         = ALU_PASS;
      halt_o           = 1'b0;
    end
  end

  // State and opcode registers; opcode latches with the IR load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ir_en_o) opc_q <= opc_i;
    end
  end

endmodule

// File: tb/tb_ctl_seq.sv
// Bench for ctl_seq: directed cycle table, halt/reset sequence, then
// randomized traffic checked against an instruction-level reference model.

`ifndef CTR_MARMUX_WIDTH
`define CTR_MARMUX_WIDTH 1
`endif
`ifndef MAR_OP_PC
`define MAR_OP_PC 0
`endif
`ifndef MAR_OP_ARG
`define MAR_OP_ARG 1
`endif

module tb_ctl_seq;
  localparam int MW = `CTR_MARMUX_WIDTH;
  localparam logic [MW-1:0] M_PC  = MW'(`MAR_OP_PC);
  localparam logic [MW-1:0] M_ARG = MW'(`MAR_OP_ARG);

  typedef logic [MW+8:0] ovec_t;

  logic          clk;
  logic          rst, ack, accz;
  logic [3:0]    opc;
  logic          stb, we, mar_en, pc_en, ir_en, acc_en, halt;
  logic [MW-1:0] marmux;
  logic [1:0]    alu;

  int checks   = 0;
  int failures = 0;

  ctl_seq #(.OPC_WIDTH(4), .CTR_MARMUX_WIDTH(MW)) dut (
    .clk_i(clk), .rst_i(rst), .opc_i(opc), .ack_i(ack), .acc_zero_i(accz),
    .stb_o(stb), .we_o(we), .ctr_marmux_o(marmux), .ctr_mar_reg_en_o(mar_en),
    .ctr_pc_reg_en_o(pc_en), .ir_en_o(ir_en), .acc_en_o(acc_en),
    .alu_op_o(alu), .halt_o(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-output code: [9]halt [8:7]alu [6]acc [5]ir [4]pc [3]mar [2]arg [1]we [0]stb
  function automatic ovec_t expand(input logic [9:0] e);
    logic [MW-1:0] m;
    m = e[2] ? M_ARG : M_PC;
    return {e[9], e[8:7], e[6], e[5], e[4], e[3], m, e[1], e[0]};
  endfunction

  function automatic ovec_t actual();
    return {halt, alu, acc_en, ir_en, pc_en, mar_en, marmux, we, stb};
  endfunction

  task automatic check(input string name, input int idx, input ovec_t exp);
    ovec_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got halt/alu/acc/ir/pc/mar/mux/we/stb=%b required %b", name, idx, act, exp);
    end
    // Structural rules that must hold every cycle.
    checks++;
    if ((mar_en && pc_en) || (we && !stb)) begin
      failures++;
      $display("FAIL %s_rules[%0d]: mar_en=%b pc_en=%b we=%b stb=%b required no mar&pc, no we w/o stb",
               name, idx, mar_en, pc_en, we, stb);
    end
  endtask

  // Inputs applied on the falling edge; outputs sampled shortly after.
  task automatic apply(input logic r, input logic [3:0] o, input logic a, input logic z);
    @(negedge clk);
    rst = r; opc = o; ack = a; accz = z;
    #2;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] opc;
    logic       ack;
    logic       accz;
    logic [9:0] e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic [3:0] o, logic a, logic z, logic [9:0] e);
    vec_t x;
    x.rst = r; x.opc = o; x.ack = a; x.accz = z; x.e = e;
    return x;
  endfunction

  // ---------------- reference model ----------------
  // Instruction-level view: an instruction is a fetch followed by the list
  // of its remaining phases (decode, then an operand access if it touches memory).
  localparam int PH_DEC = 0, PH_MEM = 1;
  int         m_todo[$];
  logic [3:0] m_op;
  bit         m_halted;

  function automatic bit op_mem(logic [3:0] o);
    return (o >= 4'h1) && (o <= 4'h5);
  endfunction

  function automatic logic [9:0] m_expect(logic r, logic a, logic z);
    logic [9:0] e;
    e = '0;
    if (r) return e;
    if (m_halted) begin e[9] = 1; return e; end
    if (m_todo.size() == 0) begin
      e[0] = 1;
      if (a) begin e[5] = 1; e[4] = 1; end
    end else if (m_todo[0] == PH_DEC) begin
      if (m_op == 4'hF) ;
      else if (op_mem(m_op) || m_op == 4'h6 || (m_op == 4'h7 && z)) begin e[3] = 1; e[2] = 1; end
      else e[3] = 1;
    end else begin
      e[0] = 1;
      e[1] = (m_op == 4'h2);
      e[8:7] = (m_op == 4'h3) ? 2'd1 : (m_op == 4'h4) ? 2'd2 : (m_op == 4'h5) ? 2'd3 : 2'd0;
      if (a) begin e[6] = (m_op != 4'h2); e[3] = 1; end
    end
    return e;
  endfunction

  task automatic m_step(logic r, logic [3:0] o, logic a);
    if (r) begin
      m_todo.delete(); m_halted = 0; m_op = 0;
    end else if (m_halted) begin
    end else if (m_todo.size() == 0) begin
      if (a) begin m_op = o; m_todo.push_back(PH_DEC); end
    end else if (m_todo[0] == PH_DEC) begin
      void'(m_todo.pop_front());
      if (op_mem(m_op)) m_todo.push_back(PH_MEM);
      if (m_op == 4'hF) m_halted = 1;
    end else if (a) begin
      void'(m_todo.pop_front());
    end
  endtask

  initial begin
    rst = 1; opc = 0; ack = 0; accz = 0;

    //              rst opc  ack z  halt alu acc ir pc mar arg we stb
    tbl.push_back(v(1, 4'h0, 1, 0, 10'b0_00_0_0_0_0_0_0_0)); // reset: all idle
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // NOP fetch
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_0_0_0)); // NOP decode
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // NOP repeats
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_0_0_0));
    tbl.push_back(v(0, 4'h1, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // LDA fetch
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_1_0_0)); // decode ARG
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_1_0_0_1_0_0_1)); // exec pass+acc
    tbl.push_back(v(0, 4'h3, 0, 0, 10'b0_00_0_0_0_0_0_0_1)); // ADD fetch wait
    tbl.push_back(v(0, 4'h3, 1, 0, 10'b0_00_0_1_1_0_0_0_1));
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_1_0_0));
    tbl.push_back(v(0, 4'h0, 0, 0, 10'b0_01_0_0_0_0_0_0_1)); // exec wait
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_01_1_0_0_1_0_0_1));
    tbl.push_back(v(0, 4'h2, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // STA
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_1_0_0));
    tbl.push_back(v(0, 4'h0, 0, 0, 10'b0_00_0_0_0_0_0_1_1)); // 3 wait cycles
    tbl.push_back(v(0, 4'h0, 0, 0, 10'b0_00_0_0_0_0_0_1_1));
    tbl.push_back(v(0, 4'h0, 0, 0, 10'b0_00_0_0_0_0_0_1_1));
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_0_1_1)); // ack: no acc_en
    tbl.push_back(v(0, 4'h7, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // JZ taken
    tbl.push_back(v(0, 4'h0, 1, 1, 10'b0_00_0_0_0_1_1_0_0));
    tbl.push_back(v(0, 4'h7, 1, 1, 10'b0_00_0_1_1_0_0_0_1)); // JZ not taken
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_0_0_0));
    tbl.push_back(v(0, 4'h9, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // illegal 9
    tbl.push_back(v(0, 4'h0, 1, 1, 10'b0_00_0_0_0_1_0_0_0));
    tbl.push_back(v(0, 4'h4, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // SUB
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_1_0_0));
    tbl.push_back(v(0, 4'h0, 0, 0, 10'b0_10_0_0_0_0_0_0_1)); // exec, no ack
    tbl.push_back(v(1, 4'h0, 1, 0, 10'b0_00_0_0_0_0_0_0_0)); // reset mid-exec
    tbl.push_back(v(0, 4'h0, 0, 0, 10'b0_00_0_0_0_0_0_0_1)); // back in fetch
    tbl.push_back(v(0, 4'h5, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // AND
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_1_0_0));
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_11_1_0_0_1_0_0_1));
    tbl.push_back(v(0, 4'h6, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // JMP
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_1_1_0_0));
    tbl.push_back(v(0, 4'hF, 1, 0, 10'b0_00_0_1_1_0_0_0_1)); // HLT
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b0_00_0_0_0_0_0_0_0)); // decode: nothing
    tbl.push_back(v(0, 4'h0, 1, 0, 10'b1_00_0_0_0_0_0_0_0)); // halted

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].opc, tbl[i].ack, tbl[i].accz);
      check("table", i, expand(tbl[i].e));
    end

    // Halt holds regardless of ack until reset.
    for (int i = 0; i < 20; i++) begin
      apply(0, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      check("halt_hold", i, expand(10'b1_00_0_0_0_0_0_0_0));
    end
    apply(1, 4'h0, 1, 0);
    check("halt_reset", 0, expand(10'b0_00_0_0_0_0_0_0_0));
    apply(0, 4'h0, 0, 0);
    check("post_reset_fetch", 0, expand(10'b0_00_0_0_0_0_0_0_1));

    // Randomized traffic; DUT is in FETCH with nothing pending.
    m_todo.delete(); m_halted = 0; m_op = 0;
    @(posedge clk);
    for (int i = 0; i < 2000; i++) begin
      logic       r, a, z;
      logic [3:0] o;
      r = ($urandom_range(0, 29) == 0);
      a = 1'($urandom);
      z = 1'($urandom);
      o = 4'($urandom_range(0, 15));
      if (o == 4'hF && $urandom_range(0, 3) != 0) o = 4'h1;
      apply(r, o, a, z);
      check("random", i, expand(m_expect(r, a, z)));
      m_step(r, o, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
